// File: rtl/clk_div_bank.sv
// clk_div_bank: bank of integer clock-enable dividers sharing one glitch-free ratio update slot
module clk_div_bank #(
   parameter int NUM_CH      = 2,
   parameter int CNT_W       = 8,
   parameter int DEFAULT_DIV = 4,
   localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   input  logic [CH_W-1:0]   cfg_ch,
   input  logic [CNT_W-1:0]  cfg_div,
   input  logic              restart,
   output logic [NUM_CH-1:0] div_out,
   output logic [NUM_CH-1:0] tick
);
   localparam logic [CNT_W-1:0] DEF_DIV = CNT_W'(DEFAULT_DIV);
   localparam logic [CH_W:0]    CH_LIM  = (CH_W+1)'(NUM_CH);

   logic [CNT_W-1:0]  cnt [NUM_CH];
   logic [CNT_W-1:0]  div [NUM_CH];
   logic              pend;
   logic [CH_W-1:0]   pend_ch;
   logic [CNT_W-1:0]  pend_div;
   logic              take;
   logic [NUM_CH-1:0] hit;

   // the slot being empty is the only thing that gates acceptance
   assign cfg_ready = !pend;
   // out-of-range indices are accepted but never reach the slot or a channel
   assign take = cfg_valid && cfg_ready && ({1'b0, cfg_ch} < CH_LIM);

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      logic [CNT_W-1:0] d;
      logic             own_new;
      logic             own_pend;
      // ratios 0 and 1 both collapse to divide-by-1
      assign d        = (div[i] == '0) ? CNT_W'(1) : div[i];
      assign tick[i]  = cnt[i] == d - CNT_W'(1);
      // one extra bit so that (255+1)>>1 does not wrap
      assign div_out[i] = {1'b0, cnt[i]} < (({1'b0, d} + (CNT_W+1)'(1)) >> 1);
      assign own_new  = take && (cfg_ch == CH_W'(i));
      assign own_pend = pend && (pend_ch == CH_W'(i));
      assign hit[i]   = own_pend && tick[i];
      // counter and ratio; a pending ratio lands only on the wrap edge or on restart
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            cnt[i] <= '0;
            div[i] <= DEF_DIV;
         end else if (restart) begin
            cnt[i] <= '0;
            if (own_new)
               div[i] <= cfg_div;
            else if (own_pend)
               div[i] <= pend_div;
         end else if (tick[i]) begin
            cnt[i] <= '0;
            if (own_pend)
               div[i] <= pend_div;
         end else begin
            cnt[i] <= cnt[i] + CNT_W'(1);
         end
      end
   end

   // single pending-update slot; restart drains it, a target wrap consumes it
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend     <= 1'b0;
         pend_ch  <= '0;
         pend_div <= '0;
      end else if (restart) begin
         pend <= 1'b0;
      end else if (pend) begin
         if (|hit)
            pend <= 1'b0;
      end else if (take) begin
         pend     <= 1'b1;
         pend_ch  <= cfg_ch;
         pend_div <= cfg_div;
      end
   end
endmodule

// File: tb/tb_clk_div_bank.sv
// tb_clk_div_bank: random and directed checks of clk_div_bank against a period/phase model
module tb_clk_div_bank;
   // three channels so that index 3 is a representable out-of-range channel
   localparam int NCH = 3;
   localparam int CW  = 8;
   localparam int DEF = 4;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           cfg_valid = 1'b0;
   logic           restart = 1'b0;
   logic [1:0]     cfg_ch = '0;
   logic [CW-1:0]  cfg_div = '0;
   logic           cfg_ready;
   logic [NCH-1:0] div_out;
   logic [NCH-1:0] tick;

   int n_chk = 0;
   int n_fail = 0;

   // model: position inside the current period and the programmed ratio per channel
   int m_pos [NCH];
   int m_ratio [NCH];
   bit m_pend;
   int m_pch;
   int m_pdiv;

   clk_div_bank #(.NUM_CH(NCH), .CNT_W(CW), .DEFAULT_DIV(DEF)) dut (
      .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
      .cfg_ch(cfg_ch), .cfg_div(cfg_div), .restart(restart),
      .div_out(div_out), .tick(tick)
   );

   // free-running system clock
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic int eff(input int r);
      return (r == 0) ? 1 : r;
   endfunction

   task automatic m_reset();
      for (int k = 0; k < NCH; k++) begin
         m_pos[k] = 0;
         m_ratio[k] = DEF;
      end
      m_pend = 0;
   endtask

   task automatic check_outs(input string tag);
      logic [NCH-1:0] et;
      logic [NCH-1:0] ed;
      for (int k = 0; k < NCH; k++) begin
         et[k] = (m_pos[k] == eff(m_ratio[k]) - 1);
         ed[k] = (m_pos[k] < (eff(m_ratio[k]) + 1) / 2);
      end
      chk({tag, " tick"}, 32'(tick), 32'(et));
      chk({tag, " div_out"}, 32'(div_out), 32'(ed));
      chk({tag, " cfg_ready"}, 32'(cfg_ready), 32'(!m_pend));
   endtask

   task automatic m_edge(input bit v, input int c, input int dv, input bit rs);
      bit acc;
      bit inr;
      bit hit;
      acc = v && !m_pend;
      inr = c < NCH;
      hit = 0;
      for (int k = 0; k < NCH; k++) begin
         if (rs) begin
            m_pos[k] = 0;
            if (acc && inr && c == k) m_ratio[k] = dv;
            else if (m_pend && m_pch == k) m_ratio[k] = m_pdiv;
         end else if (m_pos[k] == eff(m_ratio[k]) - 1) begin
            m_pos[k] = 0;
            if (m_pend && m_pch == k) begin
               m_ratio[k] = m_pdiv;
               hit = 1;
            end
         end else begin
            m_pos[k]++;
         end
      end
      if (rs || hit) m_pend = 0;
      else if (acc && inr) begin
         m_pend = 1;
         m_pch = c;
         m_pdiv = dv;
      end
   endtask

   task automatic cycle(input string tag, input bit v, input int c, input int dv, input bit rs);
      cfg_valid = v;
      cfg_ch = 2'(c);
      cfg_div = CW'(dv);
      restart = rs;
      @(posedge clk);
      m_edge(v, c, dv, rs);
      @(negedge clk);
      cfg_valid = 1'b0;
      restart = 1'b0;
      check_outs(tag);
   endtask

   task automatic idle(input string tag, input int n);
      for (int k = 0; k < n; k++) cycle(tag, 0, 0, 0, 0);
   endtask

   task automatic wait_free(input string tag);
      int w;
      w = 0;
      while (m_pend && w < 600) begin
         cycle(tag, 0, 0, 0, 0);
         w++;
      end
      chk({tag, " slot free"}, 32'(cfg_ready), 32'(1));
   endtask

   task automatic send(input string tag, input int c, input int dv);
      wait_free(tag);
      cycle(tag, 1, c, dv, 0);
   endtask

   initial begin
      int w;
      m_reset();
      repeat (2) @(negedge clk);
      check_outs("reset");
      rst_n = 1'b1;
      idle("release", 12);

      cycle("realign", 0, 0, 0, 1);
      idle("cnt1", 1);
      send("ch0=3", 0, 3);
      idle("ratio3", 12);

      send("ch1=0", 1, 0);
      idle("bypass0", 10);
      send("ch1=1", 1, 1);
      idle("bypass1", 10);

      send("ch0=200", 0, 200);
      wait_free("apply200");
      cycle("align200", 0, 0, 0, 1);
      w = 0;
      while (m_pos[0] != 9 && w < 300) begin
         cycle("run200", 0, 0, 0, 0);
         w++;
      end
      cycle("ch0=5 pend", 1, 0, 5, 0);
      cycle("restart pend", 0, 0, 0, 1);
      idle("after restart", 12);

      send("oor", 3, 7);
      idle("oor run", 5);

      wait_free("rs+cfg");
      cycle("rs+cfg", 1, 2, 6, 1);
      idle("rs+cfg run", 10);

      send("ch2=255", 2, 255);
      idle("ratio255", 600);

      send("ch2=9 pend", 2, 9);
      #1 rst_n = 1'b0;
      #1 m_reset();
      check_outs("async reset");
      #1 rst_n = 1'b1;
      idle("post reset", 12);

      for (int n = 0; n < 3000; n++) begin
         int dv;
         dv = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 9));
         cycle("random", bit'($urandom_range(0, 1)), int'($urandom_range(0, 3)), dv,
               $urandom_range(0, 40) == 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
